// File: rtl/cmd_tag_pool_pkg.sv
// Shared types for the command tag pool: FSM states, the per-tag command
// record, and the status bundles reported by the pool and its free FIFO.
package cmd_tag_pool_pkg;

  typedef enum logic [1:0] {
    TAG_POOL_RESET = 2'd0,
    TAG_POOL_INIT  = 2'd1,
    TAG_POOL_READY = 2'd2
  } tag_pool_state;

  // Command bound to a tag; the tag field is rewritten with the tag it is bound to.
  typedef struct packed {
    logic [7:0]  cu_id;
    logic [7:0]  cmd_type;
    logic [15:0] address;
    logic [7:0]  tag;
  } CommandTagLine;

  typedef struct packed {
    logic full;
    logic empty;
  } BufferStatus;

  // Status snapshot; tags_free is sized for the largest pool (256 tags).
  typedef struct packed {
    logic [8:0] tags_free;
    logic       pool_empty;
    logic       drained;
    logic       init_done;
    logic       tag_error;
  } TagPoolStatus;

endpackage

// File: rtl/cmd_tag_pool_if.sv
// Request/grant and response/lookup signals between the command channels
// and the tag pool.
//
// Handshake: tag_request[c] is a level. A tag is handed to channel c in
// the cycle where tag_valid=1 and tag_grant[c]=1; the grant acts as the
// ready for that request. The channel drops its request in that same cycle
// or it is granted again. resp_valid is a single-cycle strobe with no
// back-pressure; every resp_valid produces one lookup_valid cycle later.
interface cmd_tag_pool_if
  import cmd_tag_pool_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0] tag_request;
  CommandTagLine           cmd_in [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] tag_grant;
  logic [7:0]              tag_out;
  logic                    tag_valid;
  logic                    resp_valid;
  logic [7:0]              resp_tag;
  logic                    resp_release;
  logic                    lookup_valid;
  CommandTagLine           lookup_cmd;

  modport master (
    output tag_request, cmd_in, resp_valid, resp_tag, resp_release,
    input  tag_grant, tag_out, tag_valid, lookup_valid, lookup_cmd
  );

  modport slave (
    input  tag_request, cmd_in, resp_valid, resp_tag, resp_release,
    output tag_grant, tag_out, tag_valid, lookup_valid, lookup_cmd
  );
endinterface

// File: rtl/cmd_tag_pool_tag_free_fifo.sv
// Free-tag FIFO: DEPTH entries of 8-bit tags with an occupancy count.
// Pointers wrap by explicit compare so DEPTH need not be a power of two.
module cmd_tag_pool_tag_free_fifo
  import cmd_tag_pool_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic [CNT_W-1:0] count,
  output BufferStatus      status
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  assign pop_data     = mem[rptr];
  assign status.full  = (count == CNT_W'(DEPTH));
  assign status.empty = (count == '0);

  // Storage write; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= push_data;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cmd_tag_pool.sv
// Command tag pool: hands out PSL command tags round-robin to the command
// channels, remembers which command owns each tag, and returns that
// command on the response path.
module cmd_tag_pool
  import cmd_tag_pool_pkg::*;
#(
  parameter int NUM_TAGS     = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int TAG_CNT_W    = $clog2(NUM_TAGS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enabled,
  cmd_tag_pool_if.slave        bus,
  output logic [TAG_CNT_W-1:0] tags_free,
  output logic                 pool_empty,
  output logic                 drained,
  output logic                 init_done,
  output logic                 tag_error,
  output tag_pool_state        state_dbg
);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int IDX_W = $clog2(NUM_TAGS);

  tag_pool_state         state;
  logic [7:0]            init_tag;
  logic [NUM_TAGS-1:0]   busy;
  CommandTagLine         store [NUM_TAGS];
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       winner;
  logic                  found;
  logic                  ready;
  logic                  grant_go;
  logic                  resp_in_range;
  logic                  resp_busy;
  logic                  release_go;
  logic                  resp_bad;
  logic                  fifo_push;
  logic [7:0]            fifo_push_data;
  logic [7:0]            pop_tag;
  logic [TAG_CNT_W-1:0]  fifo_count;
  BufferStatus           fifo_status;
  logic [IDX_W-1:0]      resp_idx;
  logic [IDX_W-1:0]      pop_idx;
  CommandTagLine         cmd_sel;

  assign ready         = (state == TAG_POOL_READY);
  assign resp_idx      = bus.resp_tag[IDX_W-1:0];
  assign pop_idx       = pop_tag[IDX_W-1:0];
  assign resp_in_range = ({1'b0, bus.resp_tag} < 9'(NUM_TAGS));
  assign resp_busy     = resp_in_range && busy[resp_idx];
  assign grant_go      = ready && enabled && !fifo_status.empty && found;
  assign release_go    = ready && bus.resp_valid && bus.resp_release && resp_busy;
  // Releasing an idle or nonexistent tag, or any response before READY.
  assign resp_bad      = bus.resp_valid && (!ready || !resp_busy);

  // INIT seeds the pool; afterwards only genuine releases refill it.
  assign fifo_push      = ((state == TAG_POOL_INIT) || release_go) && !fifo_status.full;
  assign fifo_push_data = (state == TAG_POOL_INIT) ? init_tag : bus.resp_tag;

  assign tags_free  = fifo_count;
  assign pool_empty = ready && (fifo_count == '0);
  assign drained    = ready && (fifo_count == TAG_CNT_W'(NUM_TAGS));
  assign init_done  = ready;
  assign state_dbg  = state;

  cmd_tag_pool_tag_free_fifo #(
    .DEPTH (NUM_TAGS),
    .CNT_W (TAG_CNT_W)
  ) u_free_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (grant_go),
    .pop_data  (pop_tag),
    .count     (fifo_count),
    .status    (fifo_status)
  );

  // Round-robin pick: first requesting channel at or after rr_ptr.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CHANNELS;
      if (!found && bus.tag_request[idx]) begin
        winner = CH_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // Winning channel's command, stamped with the tag it is being bound to.
  always_comb begin
    cmd_sel     = bus.cmd_in[winner];
    cmd_sel.tag = pop_tag;
  end

  // Tag store write at grant; abandoned on reset, so no reset needed.
  always_ff @(posedge clock) begin
    if (grant_go) store[pop_idx] <= cmd_sel;
  end

  // Pool FSM plus registered grant, lookup and error outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= TAG_POOL_RESET;
      init_tag         <= '0;
      busy             <= '0;
      rr_ptr           <= '0;
      bus.tag_valid    <= 1'b0;
      bus.tag_grant    <= '0;
      bus.tag_out      <= '0;
      bus.lookup_valid <= 1'b0;
      bus.lookup_cmd   <= '0;
      tag_error        <= 1'b0;
    end else begin
      case (state)
        TAG_POOL_RESET: begin
          state    <= TAG_POOL_INIT;
          init_tag <= '0;
        end
        TAG_POOL_INIT: begin
          init_tag <= init_tag + 1'b1;
          if (init_tag == 8'(NUM_TAGS - 1)) state <= TAG_POOL_READY;
        end
        TAG_POOL_READY: state <= TAG_POOL_READY;
        default:        state <= TAG_POOL_RESET;
      endcase

      bus.tag_valid <= grant_go;
      bus.tag_grant <= grant_go ? (NUM_CHANNELS'(1) << winner) : '0;
      bus.tag_out   <= grant_go ? pop_tag : '0;
      if (grant_go) begin
        rr_ptr        <= (winner == CH_W'(NUM_CHANNELS - 1)) ? '0 : winner + 1'b1;
        busy[pop_idx] <= 1'b1;
      end
      // The popped tag is free, so it never collides with the released one.
      if (release_go) busy[resp_idx] <= 1'b0;

      bus.lookup_valid <= ready && bus.resp_valid;
      if (ready && bus.resp_valid) begin
        if (resp_in_range) bus.lookup_cmd <= store[resp_idx];
        bus.lookup_cmd.tag <= bus.resp_tag;
      end

      if (resp_bad) tag_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cmd_tag_pool.sv
// Directed bench for cmd_tag_pool with NUM_TAGS=32, NUM_CHANNELS=4.
module tb_cmd_tag_pool;
  import cmd_tag_pool_pkg::*;

  logic          clock;
  logic          reset;
  logic          enabled;
  logic [5:0]    tags_free;
  logic          pool_empty;
  logic          drained;
  logic          init_done;
  logic          tag_error;
  tag_pool_state state_dbg;

  int checks = 0;
  int errors = 0;

  cmd_tag_pool_if #(.NUM_CHANNELS(4)) bus ();

  cmd_tag_pool #(
    .NUM_TAGS     (32),
    .NUM_CHANNELS (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enabled    (enabled),
    .bus        (bus.slave),
    .tags_free  (tags_free),
    .pool_empty (pool_empty),
    .drained    (drained),
    .init_done  (init_done),
    .tag_error  (tag_error),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic CommandTagLine mk(input logic [7:0] cu, input logic [7:0] typ,
                                       input logic [15:0] addr, input logic [7:0] tag);
    CommandTagLine c;
    c.cu_id    = cu;
    c.cmd_type = typ;
    c.address  = addr;
    c.tag      = tag;
    return c;
  endfunction

  // One response cycle; the strobe is dropped again after the edge.
  task automatic respond(input logic [7:0] t, input logic rel);
    bus.resp_valid   = 1'b1;
    bus.resp_tag     = t;
    bus.resp_release = rel;
    step();
    bus.resp_valid   = 1'b0;
    bus.resp_release = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " tag_valid"},    64'(bus.tag_valid), 64'(0));
    check({name, " tag_grant"},    64'(bus.tag_grant), 64'(0));
    check({name, " tag_out"},      64'(bus.tag_out), 64'(0));
    check({name, " lookup_valid"}, 64'(bus.lookup_valid), 64'(0));
    check({name, " lookup_cmd"},   64'(bus.lookup_cmd), 64'(0));
    check({name, " tags_free"},    64'(tags_free), 64'(0));
    check({name, " pool_empty"},   64'(pool_empty), 64'(0));
    check({name, " drained"},      64'(drained), 64'(0));
    check({name, " init_done"},    64'(init_done), 64'(0));
    check({name, " tag_error"},    64'(tag_error), 64'(0));
    check({name, " state"},        64'(state_dbg), 64'(TAG_POOL_RESET));
  endtask

  initial begin
    logic [7:0]  exp_tag;
    logic [3:0]  exp_grant;
    int          n;

    reset            = 1'b1;
    enabled          = 1'b1;
    bus.tag_request  = '0;
    bus.resp_valid   = 1'b0;
    bus.resp_tag     = '0;
    bus.resp_release = 1'b0;
    for (int c = 0; c < 4; c++) bus.cmd_in[c] = '0;

    // Reset state
    step();
    step();
    check_all_zero("reset");

    // Init: RESET->INIT on edge 1, pushes on edges 2..33
    reset = 1'b0;
    for (int i = 0; i < 32; i++) step();
    check("init not done at 32", 64'(init_done), 64'(0));
    check("init tags_free at 32", 64'(tags_free), 64'(31));
    step();
    check("init_done at 33", 64'(init_done), 64'(1));
    check("init tags_free", 64'(tags_free), 64'(32));
    check("init drained", 64'(drained), 64'(1));
    check("init pool_empty", 64'(pool_empty), 64'(0));

    // Channel 2 alone for 3 cycles: tags 0, 1, 2
    bus.tag_request = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      bus.cmd_in[2] = mk(8'h02, 8'h01, 16'h0100 + 16'(i), 8'h00);
      step();
      check("ch2 tag_valid", 64'(bus.tag_valid), 64'(1));
      check("ch2 tag_grant", 64'(bus.tag_grant), 64'(4'b0100));
      check("ch2 tag_out", 64'(bus.tag_out), 64'(i));
    end
    bus.tag_request = '0;
    check("ch2 tags_free", 64'(tags_free), 64'(29));
    check("ch2 drained", 64'(drained), 64'(0));

    respond(8'd1, 1'b1);
    check("release1 lookup_valid", 64'(bus.lookup_valid), 64'(1));
    check("release1 lookup_cmd", 64'(bus.lookup_cmd), 64'(mk(8'h02, 8'h01, 16'h0101, 8'h01)));
    check("release1 tags_free", 64'(tags_free), 64'(30));
    check("release1 no grant", 64'(bus.tag_valid), 64'(0));

    // All four channels: pointer sits after channel 2, so 3,0,1,2,3,0,1,2; tags 3..10
    for (int c = 0; c < 4; c++)
      bus.cmd_in[c] = mk(8'h10 + 8'(c), 8'hA0 + 8'(c), 16'h1000 + 16'(c), 8'hFF);
    bus.tag_request = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_grant = 4'b0001 << ((i + 3) % 4);
      check("rr tag_grant", 64'(bus.tag_grant), 64'(exp_grant));
      check("rr tag_out", 64'(bus.tag_out), 64'(3 + i));
    end
    bus.tag_request = '0;
    check("rr tags_free", 64'(tags_free), 64'(22));

    // Exhaust: channel 0 gets 11..31 then the recycled tag 1
    bus.tag_request = 4'b0001;
    for (int i = 0; i < 22; i++) begin
      step();
      exp_tag = (i < 21) ? 8'(11 + i) : 8'd1;
      check("exhaust tag_out", 64'(bus.tag_out), 64'(exp_tag));
      check("exhaust tag_grant", 64'(bus.tag_grant), 64'(4'b0001));
    end
    check("exhaust pool_empty", 64'(pool_empty), 64'(1));
    check("exhaust tags_free", 64'(tags_free), 64'(0));
    step();
    check("empty no tag_valid", 64'(bus.tag_valid), 64'(0));

    // Release 7 while the request is pending; re-granted one cycle later
    respond(8'd7, 1'b1);
    check("rel7 no grant yet", 64'(bus.tag_valid), 64'(0));
    check("rel7 tags_free", 64'(tags_free), 64'(1));
    step();
    check("rel7 tag_valid", 64'(bus.tag_valid), 64'(1));
    check("rel7 tag_out", 64'(bus.tag_out), 64'(7));
    bus.tag_request = '0;
    step();
    check("rel7 tags_free after", 64'(tags_free), 64'(0));

    // Tag 5 (channel 1 command): keep, then free, then a bad third release
    respond(8'd5, 1'b0);
    check("keep5 lookup_valid", 64'(bus.lookup_valid), 64'(1));
    check("keep5 lookup_cmd", 64'(bus.lookup_cmd), 64'(mk(8'h11, 8'hA1, 16'h1001, 8'h05)));
    check("keep5 tags_free", 64'(tags_free), 64'(0));
    check("keep5 tag_error", 64'(tag_error), 64'(0));
    respond(8'd5, 1'b1);
    check("free5 tags_free", 64'(tags_free), 64'(1));
    check("free5 tag_error", 64'(tag_error), 64'(0));
    respond(8'd5, 1'b1);
    check("bad5 tag_error", 64'(tag_error), 64'(1));
    check("bad5 tags_free", 64'(tags_free), 64'(1));
    check("bad5 lookup_valid", 64'(bus.lookup_valid), 64'(1));

    // Return 11..31, leaving 0..4 and 6..10 outstanding
    for (int t = 11; t < 32; t++) begin
      respond(8'(t), 1'b1);
      check("bulk tags_free", 64'(tags_free), 64'(t - 9));
    end

    // Drain with enabled low: no grants despite a request
    enabled = 1'b0;
    bus.tag_request = 4'b1000;
    n = 0;
    for (int t = 0; t <= 10; t++) begin
      if (t != 5) begin
        respond(8'(t), 1'b1);
        n++;
        check("drain no grant", 64'(bus.tag_valid), 64'(0));
        check("drain tags_free", 64'(tags_free), 64'(22 + n));
        check("drain drained", 64'(drained), 64'(n == 10));
      end
    end

    // Mid-run reset after a couple of fresh grants
    enabled = 1'b1;
    bus.tag_request = 4'b0001;
    step();
    step();
    check("pre-reset grant", 64'(bus.tag_valid), 64'(1));
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    step();
    reset = 1'b0;
    step();
    check("reinit state", 64'(state_dbg), 64'(TAG_POOL_INIT));
    check("reinit tags_free", 64'(tags_free), 64'(0));
    step();
    check("reinit first push", 64'(tags_free), 64'(1));
    check("reinit no grant", 64'(bus.tag_valid), 64'(0));
    for (int i = 0; i < 31; i++) step();
    check("reinit init_done", 64'(init_done), 64'(1));
    check("reinit tag_error", 64'(tag_error), 64'(0));
    step();
    check("reinit grant tag", 64'(bus.tag_out), 64'(0));
    check("reinit grant ch0", 64'(bus.tag_grant), 64'(4'b0001));
    bus.tag_request = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
